// File: rtl/inst_fetch_mod_if.sv
// Fetch-stage bundle: control-unit request/response plus the memory read bus.
// The master modport is the fetch unit; the slave modport is its environment.
interface inst_fetch_if;
   logic        inst_req;
   logic        imm_req;
   logic        pc_load;
   logic [15:0] pc_load_value;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [8:0]  inst_opcode;
   logic        inst_valid;
   logic [7:0]  imm_data;
   logic        imm_valid;
   logic [15:0] pc;

   modport master (
      input  inst_req, imm_req, pc_load, pc_load_value, mem_rdata, mem_ack,
      output mem_addr, mem_rd, inst_opcode, inst_valid, imm_data, imm_valid, pc
   );

   modport slave (
      output inst_req, imm_req, pc_load, pc_load_value, mem_rdata, mem_ack,
      input  mem_addr, mem_rd, inst_opcode, inst_valid, imm_data, imm_valid, pc
   );
endinterface

// File: rtl/inst_fetch_mod.sv
// Instruction fetch stage: owns the PC, fetches opcode/immediate bytes over the bus.
// Define CB_PREFIX_EN to make a CB prefix byte fetch a second opcode byte.
module inst_fetch_mod #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [7:0]  CB_OPCODE = 8'hCB
) (
   input  logic         clock,
   input  logic         reset,
   inst_fetch_if.master bus
);

`ifdef CB_PREFIX_EN
   typedef enum logic [1:0] {IDLE, FETCH_OP, FETCH_CB, FETCH_IMM} state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH_OP, FETCH_IMM} state_t;
`endif

   state_t      state_q;
   logic [15:0] pc_q;
   logic        mem_rd_q;
   logic [8:0]  inst_opcode_q;
   logic        inst_valid_q;
   logic [7:0]  imm_data_q;
   logic        imm_valid_q;
   logic [15:0] pc_inc;

   assign pc_inc = pc_q + 16'd1;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         mem_rd_q      <= 1'b0;
         inst_opcode_q <= 9'h000;
         inst_valid_q  <= 1'b0;
         imm_data_q    <= 8'h00;
         imm_valid_q   <= 1'b0;
      end else if (bus.pc_load) begin
         // Jump aborts any fetch in flight; a same-cycle ack or request is dropped.
         state_q      <= IDLE;
         pc_q         <= bus.pc_load_value;
         mem_rd_q     <= 1'b0;
         inst_valid_q <= 1'b0;
         imm_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.inst_req) begin
                  state_q      <= FETCH_OP;
                  mem_rd_q     <= 1'b1;
                  inst_valid_q <= 1'b0;
               end else if (bus.imm_req) begin
                  state_q     <= FETCH_IMM;
                  mem_rd_q    <= 1'b1;
                  imm_valid_q <= 1'b0;
               end
            end
            FETCH_OP: begin
               if (bus.mem_ack) begin
                  pc_q <= pc_inc;
`ifdef CB_PREFIX_EN
                  if (bus.mem_rdata == CB_OPCODE) begin
                     state_q <= FETCH_CB;
                  end else begin
                     state_q       <= IDLE;
                     mem_rd_q      <= 1'b0;
                     inst_opcode_q <= {1'b0, bus.mem_rdata};
                     inst_valid_q  <= 1'b1;
                  end
`else
                  state_q       <= IDLE;
                  mem_rd_q      <= 1'b0;
                  inst_opcode_q <= {1'b0, bus.mem_rdata};
                  inst_valid_q  <= 1'b1;
`endif
               end
            end
`ifdef CB_PREFIX_EN
            FETCH_CB: begin
               if (bus.mem_ack) begin
                  pc_q          <= pc_inc;
                  state_q       <= IDLE;
                  mem_rd_q      <= 1'b0;
                  inst_opcode_q <= {1'b1, bus.mem_rdata};
                  inst_valid_q  <= 1'b1;
               end
            end
`endif
            FETCH_IMM: begin
               if (bus.mem_ack) begin
                  pc_q        <= pc_inc;
                  state_q     <= IDLE;
                  mem_rd_q    <= 1'b0;
                  imm_data_q  <= bus.mem_rdata;
                  imm_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               mem_rd_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_addr    = pc_q;
   assign bus.pc          = pc_q;
   assign bus.mem_rd      = mem_rd_q;
   assign bus.inst_opcode = inst_opcode_q;
   assign bus.inst_valid  = inst_valid_q;
   assign bus.imm_data    = imm_data_q;
   assign bus.imm_valid   = imm_valid_q;

endmodule

// File: tb/tb_inst_fetch_mod.sv
// Directed bench for inst_fetch_mod: byte-wide memory model with stallable ack,
// expected opcodes/immediates queued at request time and popped on valid.
module tb_inst_fetch_mod;
   logic clock = 1'b0;
   logic reset;
   logic ack_en;
   logic [7:0] mem [0:65535];
   int rd_cnt = 0;
   int n_checks = 0;
   int n_fail = 0;
   logic [8:0] exp_op_q[$];
   logic [7:0] exp_imm_q[$];

   inst_fetch_if ifc();

   inst_fetch_mod dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clock = ~clock;

   assign ifc.mem_rdata = mem[ifc.mem_addr];
   assign ifc.mem_ack   = ifc.mem_rd & ack_en;

   always @(posedge clock) if (ifc.mem_rd && ifc.mem_ack) rd_cnt <= rd_cnt + 1;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_pc(input logic [15:0] v);
      ifc.pc_load = 1'b1;
      ifc.pc_load_value = v;
      step();
      ifc.pc_load = 1'b0;
   endtask

   // Issue one inst_req; stall holds ack low for that many cycles, hammer keeps
   // re-requesting while busy, both raises imm_req alongside the first request.
   task automatic fetch_inst(input string tag, input logic [8:0] exp, input int lat,
                             input int stall, input int reads, input logic hammer,
                             input logic both);
      int n;
      int r0;
      logic [15:0] pc0;
      logic [8:0] e;
      exp_op_q.push_back(exp);
      r0  = rd_cnt;
      pc0 = ifc.pc;
      ifc.inst_req = 1'b1;
      ifc.imm_req  = both;
      ack_en = (stall == 0);
      step();
      ifc.inst_req = 1'b0;
      ifc.imm_req  = 1'b0;
      n = 1;
      while (!ifc.inst_valid && n < 40) begin
         if (n == stall + 1) ack_en = 1'b1;
         if (n <= stall) begin
            check({tag, "_pc_stall"}, ifc.pc, pc0);
            check({tag, "_rd_stall"}, ifc.mem_rd, 1);
         end
         ifc.inst_req = hammer;
         step();
         n++;
      end
      ifc.inst_req = 1'b0;
      ack_en = 1'b1;
      check({tag, "_timeout"}, n < 40, 1);
      check({tag, "_latency"}, n, lat);
      check({tag, "_reads"}, rd_cnt - r0, reads);
      if (exp_op_q.size() > 0) begin
         e = exp_op_q.pop_front();
         check({tag, "_opcode"}, ifc.inst_opcode, e);
      end
   endtask

   initial begin
      int n;
      logic [7:0] ei;
      reset = 1'b0;
      ack_en = 1'b1;
      ifc.inst_req = 1'b0;
      ifc.imm_req = 1'b0;
      ifc.pc_load = 1'b0;
      ifc.pc_load_value = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0010] = 8'hCB;
      mem[16'h0011] = 8'h37;
      mem[16'h0020] = 8'h42;
      mem[16'hFFFF] = 8'h5A;
      mem[16'h0140] = 8'h77;
      mem[16'h0150] = 8'h3C;
      mem[16'h0151] = 8'h12;

      repeat (3) step();
      check("rst_pc", ifc.pc, 16'h0000);
      check("rst_addr", ifc.mem_addr, 16'h0000);
      check("rst_rd", ifc.mem_rd, 0);
      check("rst_ivalid", ifc.inst_valid, 0);
      check("rst_opcode", ifc.inst_opcode, 9'h000);
      check("rst_imvalid", ifc.imm_valid, 0);
      check("rst_imdata", ifc.imm_data, 8'h00);
      reset = 1'b1;
      step();

      fetch_inst("zero_wait", 9'h000, 2, 0, 1, 1'b0, 1'b0);
      check("zero_wait_pc", ifc.pc, 16'h0001);
      repeat (3) step();
      check("hold_valid", ifc.inst_valid, 1);
      check("hold_rd", ifc.mem_rd, 0);

      load_pc(16'h0010);
      check("load_pc", ifc.pc, 16'h0010);
      check("load_clr_valid", ifc.inst_valid, 0);
`ifdef CB_PREFIX_EN
      fetch_inst("cb", 9'h137, 3, 0, 2, 1'b0, 1'b0);
      check("cb_pc", ifc.pc, 16'h0012);
`else
      fetch_inst("cb", 9'h0CB, 2, 0, 1, 1'b0, 1'b0);
      check("cb_pc", ifc.pc, 16'h0011);
`endif

      load_pc(16'h0020);
      fetch_inst("wait3", 9'h042, 5, 3, 1, 1'b0, 1'b0);
      check("wait3_pc", ifc.pc, 16'h0021);

      load_pc(16'hFFFF);
      exp_imm_q.push_back(8'h5A);
      ifc.imm_req = 1'b1;
      step();
      ifc.imm_req = 1'b0;
      check("imm_rd", ifc.mem_rd, 1);
      check("imm_addr", ifc.mem_addr, 16'hFFFF);
      n = 1;
      while (!ifc.imm_valid && n < 40) begin
         step();
         n++;
      end
      check("imm_latency", n, 2);
      ei = exp_imm_q.pop_front();
      check("imm_data", ifc.imm_data, ei);
      check("imm_wrap_pc", ifc.pc, 16'h0000);
      check("imm_no_inst", ifc.inst_valid, 0);

      load_pc(16'h0140);
      ifc.inst_req = 1'b1;
      step();
      ifc.inst_req = 1'b0;
      check("abort_busy", ifc.mem_rd, 1);
      ifc.pc_load = 1'b1;
      ifc.pc_load_value = 16'h0150;
      step();
      ifc.pc_load = 1'b0;
      check("abort_valid", ifc.inst_valid, 0);
      check("abort_pc", ifc.pc, 16'h0150);
      check("abort_rd", ifc.mem_rd, 0);
      step();
      check("abort_still_idle", ifc.inst_valid, 0);
      check("abort_imm_clr", ifc.imm_valid, 0);
      fetch_inst("after_abort", 9'h03C, 2, 0, 1, 1'b0, 1'b0);
      check("after_abort_pc", ifc.pc, 16'h0151);

      fetch_inst("both_req", 9'h012, 5, 3, 1, 1'b1, 1'b1);
      check("both_imm_valid", ifc.imm_valid, 0);
      check("both_pc", ifc.pc, 16'h0152);
      repeat (2) step();
      check("both_no_refetch", ifc.mem_rd, 0);
      check("both_pc_stable", ifc.pc, 16'h0152);
      check("both_opcode_hold", ifc.inst_opcode, 9'h012);

      check("op_queue_empty", exp_op_q.size(), 0);
      check("imm_queue_empty", exp_imm_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
